// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, RAM handshake states and memory arbiter states.
package cpu_types_pkg;

    localparam int unsigned WORD_BITS = 32;
    localparam int unsigned STARVE_W  = 3;

    typedef logic [WORD_BITS-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RETRY = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the icache refill port and the dcache port onto one single-ported RAM.
// Dcache has priority; a streak counter forces the icache in after STARVE_MAX dcache wins.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned WORD_W     = WORD_BITS
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic                iREN,
    input  logic [WORD_W-1:0]   iaddr,
    output logic                iwait,
    output logic [WORD_W-1:0]   iload,
    input  logic                dREN,
    input  logic                dWEN,
    input  logic [WORD_W-1:0]   daddr,
    input  logic [WORD_W-1:0]   dstore,
    output logic                dwait,
    output logic [WORD_W-1:0]   dload,
    output logic                ramREN,
    output logic                ramWEN,
    output logic [WORD_W-1:0]   ramaddr,
    output logic [WORD_W-1:0]   ramstore,
    input  logic [WORD_W-1:0]   ramload,
    input  ramstate_t           ramstate,
    output logic [STARVE_W-1:0] starve_cnt
);

    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    arb_state_t          state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                dreq;

    assign dreq       = dREN | dWEN;
    assign starve_cnt = starve_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Next state, streak update and RAM/cache handshake outputs.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = iREN;
        dwait    = dreq;
        iload    = ramload;
        dload    = ramload;

        case (state_q)
            IDLE: begin
                if (dreq && !(iREN && (starve_q == STARVE_LIM))) begin
                    state_d = GNT_D;
                end else if (iREN) begin
                    state_d = GNT_I;
                end
            end

            GNT_D: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (!dreq) begin
                    state_d = IDLE;
                end else begin
                    ramWEN = dWEN;
                    ramREN = dREN && !dWEN;
                    if (ramstate == ACCESS) begin
                        dwait   = 1'b0;
                        state_d = IDLE;
                        if (iREN) begin
                            starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM
                                                                : starve_q + STARVE_W'(1);
                        end else begin
                            starve_d = '0;
                        end
                    end else if (ramstate == ERROR) begin
                        state_d = RETRY;
                    end
                end
            end

            GNT_I: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ramstate == ACCESS) begin
                    iwait    = 1'b0;
                    starve_d = '0;
                    state_d  = IDLE;
                end else if (ramstate == ERROR) begin
                    state_d = RETRY;
                end
            end

            // Dead cycle after a RAM error; IDLE then re-arbitrates from scratch.
            RETRY: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector tables, hand-written corner
// sequences, then randomized traffic against a transaction-level ownership model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int unsigned MAXS = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    ramstate_t   ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [2:0]  starve_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.STARVE_MAX(MAXS), .WORD_W(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .starve_cnt(starve_cnt)
    );

    typedef struct {
        logic        iren, dren, dwen;
        ramstate_t   rs;
        logic        e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        logic        e_iwait, e_dwait;
        logic [2:0]  e_starve;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic ir, logic dr, logic dw, ramstate_t rs,
                                logic er, logic ew, logic [31:0] ea, logic [31:0] es,
                                logic eiw, logic edw, logic [2:0] est);
        vec_t v;
        v.iren = ir; v.dren = dr; v.dwen = dw; v.rs = rs;
        v.e_ren = er; v.e_wen = ew; v.e_addr = ea; v.e_store = es;
        v.e_iwait = eiw; v.e_dwait = edw; v.e_starve = est;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one vector now and compare the combinational response 1ns later.
    task automatic apply(input string tag, input vec_t v);
        iREN = v.iren; dREN = v.dren; dWEN = v.dwen; ramstate = v.rs;
        #1;
        chk({tag, " ramREN"},   32'(ramREN),     32'(v.e_ren));
        chk({tag, " ramWEN"},   32'(ramWEN),     32'(v.e_wen));
        chk({tag, " ramaddr"},  ramaddr,         v.e_addr);
        chk({tag, " ramstore"}, ramstore,        v.e_store);
        chk({tag, " iwait"},    32'(iwait),      32'(v.e_iwait));
        chk({tag, " dwait"},    32'(dwait),      32'(v.e_dwait));
        chk({tag, " starve"},   32'(starve_cnt), 32'(v.e_starve));
        chk({tag, " iload"},    iload,           ramload);
        chk({tag, " dload"},    dload,           ramload);
    endtask

    task automatic step(input string tag, input vec_t v);
        @(negedge CLK);
        apply(tag, v);
    endtask

    localparam logic [31:0] IA = 32'h0000_0040;
    localparam logic [31:0] DA = 32'h0000_0100;
    localparam logic [31:0] DS = 32'hDEAD_BEEF;

    // Reference model: who owns the RAM, whether a post-error dead cycle is due, streak.
    int owner;   // 0 none, 1 icache, 2 dcache
    bit dead;
    int streak;

    task automatic random_phase(input int ncyc);
        logic        dreq, e_ren, e_wen, i_done, d_done;
        logic [31:0] e_addr, e_store;
        int          r;
        owner = 0; dead = 0; streak = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge CLK);
            if ($urandom_range(0, 5) == 0) iREN = ~iREN;
            if ($urandom_range(0, 5) == 0) dREN = ~dREN;
            if ($urandom_range(0, 7) == 0) dWEN = ~dWEN;
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            r = int'($urandom_range(0, 99));
            ramstate = (r < 40) ? ACCESS : (r < 70) ? BUSY : (r < 85) ? FREE : ERROR;
            #1;
            dreq = dREN | dWEN;
            e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
            if (owner == 2) begin
                e_addr = daddr; e_store = dstore;
                if (dreq) begin e_wen = dWEN; e_ren = dREN && !dWEN; end
            end else if (owner == 1) begin
                e_addr = iaddr; e_ren = iREN;
            end
            i_done = (owner == 1) && iREN && (ramstate == ACCESS);
            d_done = (owner == 2) && dreq && (ramstate == ACCESS);
            chk($sformatf("rnd%0d ramREN", c),   32'(ramREN),     32'(e_ren));
            chk($sformatf("rnd%0d ramWEN", c),   32'(ramWEN),     32'(e_wen));
            chk($sformatf("rnd%0d ramaddr", c),  ramaddr,         e_addr);
            chk($sformatf("rnd%0d ramstore", c), ramstore,        e_store);
            chk($sformatf("rnd%0d iwait", c),    32'(iwait),      32'(iREN && !i_done));
            chk($sformatf("rnd%0d dwait", c),    32'(dwait),      32'(dreq && !d_done));
            chk($sformatf("rnd%0d starve", c),   32'(starve_cnt), 32'(streak));
            chk($sformatf("rnd%0d iload", c),    iload,           ramload);
            chk($sformatf("rnd%0d dload", c),    dload,           ramload);
            @(posedge CLK);
            if (dead) begin
                dead = 0;
            end else if (owner == 0) begin
                if (dreq && !(iREN && streak == int'(MAXS))) owner = 2;
                else if (iREN) owner = 1;
            end else if (owner == 2) begin
                if (!dreq) owner = 0;
                else if (ramstate == ACCESS) begin
                    streak = iREN ? ((streak + 1 > int'(MAXS)) ? int'(MAXS) : streak + 1) : 0;
                    owner  = 0;
                end else if (ramstate == ERROR) begin
                    owner = 0; dead = 1;
                end
            end else begin
                if (!iREN) owner = 0;
                else if (ramstate == ACCESS) begin
                    streak = 0; owner = 0;
                end else if (ramstate == ERROR) begin
                    owner = 0; dead = 1;
                end
            end
        end
    endtask

    initial begin
        nRST = 1'b0;
        iREN = 1'b1; dREN = 1'b0; dWEN = 1'b0;
        iaddr = IA; daddr = DA; dstore = DS; ramload = 32'h8C22_0004;
        ramstate = FREE;

        // Reset state.
        #1;
        chk("reset ramREN", 32'(ramREN), 32'd0);
        chk("reset iwait",  32'(iwait),  32'd1);
        chk("reset starve", 32'(starve_cnt), 32'd0);
        @(negedge CLK); @(negedge CLK);
        nRST = 1'b1;
        iREN = 1'b0;

        // Icache refill with BUSY wait states.
        tbl.push_back(mk(1,0,0,FREE,   0,0,32'h0,32'h0, 1,0,0));
        tbl.push_back(mk(1,0,0,BUSY,   1,0,IA,32'h0,    1,0,0));
        tbl.push_back(mk(1,0,0,BUSY,   1,0,IA,32'h0,    1,0,0));
        tbl.push_back(mk(1,0,0,ACCESS, 1,0,IA,32'h0,    0,0,0));
        tbl.push_back(mk(0,0,0,FREE,   0,0,32'h0,32'h0, 0,0,0));
        // Simultaneous icache read and dcache write: dcache first, one IDLE gap.
        tbl.push_back(mk(1,0,1,FREE,   0,0,32'h0,32'h0, 1,1,0));
        tbl.push_back(mk(1,0,1,ACCESS, 0,1,DA,DS,       1,0,0));
        tbl.push_back(mk(1,0,0,FREE,   0,0,32'h0,32'h0, 1,0,1));
        tbl.push_back(mk(1,0,0,ACCESS, 1,0,IA,32'h0,    0,0,1));
        tbl.push_back(mk(0,0,0,FREE,   0,0,32'h0,32'h0, 0,0,0));
        // Starvation: four dcache wins, then the icache is forced in.
        for (int k = 0; k < 4; k++) begin
            tbl.push_back(mk(1,1,0,FREE,   0,0,32'h0,32'h0, 1,1,3'(k)));
            tbl.push_back(mk(1,1,0,ACCESS, 1,0,DA,DS,       1,0,3'(k)));
        end
        tbl.push_back(mk(1,1,0,FREE,   0,0,32'h0,32'h0, 1,1,3'd4));
        tbl.push_back(mk(1,1,0,ACCESS, 1,0,IA,32'h0,    0,1,3'd4));
        tbl.push_back(mk(0,0,0,FREE,   0,0,32'h0,32'h0, 0,0,0));
        foreach (tbl[i]) step($sformatf("tbl%0d", i), tbl[i]);

        // RAM error on a dcache read: dead cycle ignores ramstate, then re-grant.
        step("err0", mk(0,1,0,FREE,   0,0,32'h0,32'h0, 0,1,0));
        step("err1", mk(0,1,0,ERROR,  1,0,DA,DS,       0,1,0));
        step("err2", mk(0,1,0,ACCESS, 0,0,32'h0,32'h0, 0,1,0));
        step("err3", mk(0,1,0,FREE,   0,0,32'h0,32'h0, 0,1,0));
        @(negedge CLK);
        ramload = 32'h1234_5678;
        apply("err4", mk(0,1,0,ACCESS, 1,0,DA,DS, 0,0,0));
        chk("err4 dload value", dload, 32'h1234_5678);
        step("err5", mk(0,0,0,FREE,   0,0,32'h0,32'h0, 0,0,0));

        // Dcache drops its request mid-grant: strobes fall at once, no wait pulse.
        step("drop0", mk(0,1,0,FREE, 0,0,32'h0,32'h0, 0,1,0));
        step("drop1", mk(0,1,0,BUSY, 1,0,DA,DS,       0,1,0));
        step("drop2", mk(0,0,0,BUSY, 0,0,DA,DS,       0,0,0));
        step("drop3", mk(1,0,0,FREE, 0,0,32'h0,32'h0, 1,0,0));
        step("drop4", mk(1,0,0,ACCESS,1,0,IA,32'h0,   0,0,0));
        step("drop5", mk(0,0,0,FREE, 0,0,32'h0,32'h0, 0,0,0));

        // Asynchronous reset in the middle of an icache grant.
        step("rst0", mk(1,1,0,FREE,   0,0,32'h0,32'h0, 1,1,0));
        step("rst1", mk(1,1,0,ACCESS, 1,0,DA,DS,       1,0,0));
        step("rst2", mk(1,0,0,FREE,   0,0,32'h0,32'h0, 1,0,1));
        step("rst3", mk(1,0,0,BUSY,   1,0,IA,32'h0,    1,0,1));
        #2;
        nRST = 1'b0;
        #1;
        chk("rst async ramREN",  32'(ramREN),     32'd0);
        chk("rst async ramaddr", ramaddr,         32'd0);
        chk("rst async starve",  32'(starve_cnt), 32'd0);
        chk("rst async iwait",   32'(iwait),      32'd1);
        @(negedge CLK);
        nRST = 1'b1;
        apply("rst4", mk(1,0,0,FREE,   0,0,32'h0,32'h0, 1,0,0));
        step("rst5",  mk(1,0,0,ACCESS, 1,0,IA,32'h0,    0,0,0));
        step("rst6",  mk(0,0,0,FREE,   0,0,32'h0,32'h0, 0,0,0));

        random_phase(3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
